tt_capture: RTL

Sequential truth-table capture engine for the single-output combinational functions in the projection benchmark set. It is the read side of those generated functions. It drives every input vector 0..2^NIN−1 onto the function under test and samples the 1-bit response. It then packs the responses LSB-first into WORD-bit words and streams them out over a valid/ready interface. It sits between an 8-input/1-output combinational netlist (driven by `x`, returning `y`) and the downstream equivalence checker or memory writer.

---
 rtl/tt_capture.sv | 95 +++++++++
 1 files changed

// File: rtl/tt_capture.sv
// Truth-table capture engine: sweeps x over all minterms, samples y,
// packs responses LSB-first into words and streams them out.
module tt_capture #(
  parameter int NIN  = 8,
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic [NIN-1:0]  x,
  input  logic            y,
  output logic [WORD-1:0] tt_data,
  output logic            tt_valid,
  input  logic            tt_ready,
  output logic            tt_last,
  output logic [NIN:0]    ones,
  output logic            done
);

  localparam int NWORDS = (1 << NIN) / WORD;
  localparam int BW = (WORD > 1) ? $clog2(WORD) : 1;
  localparam int WW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PUSH
  } state_t;

  state_t          state;
  logic [BW-1:0]   bit_idx;
  logic [WW-1:0]   word_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      x        <= '0;
      tt_data  <= '0;
      tt_valid <= 1'b0;
      tt_last  <= 1'b0;
      ones     <= '0;
      done     <= 1'b0;
      bit_idx  <= '0;
      word_idx <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            x        <= '0;
            bit_idx  <= '0;
            word_idx <= '0;
            ones     <= '0;
            tt_data  <= '0;
          end
        end
        RUN: begin
          tt_data[bit_idx] <= y;
          ones    <= ones + (NIN+1)'(y);
          x       <= x + NIN'(1);
          bit_idx <= bit_idx + BW'(1);
          if (bit_idx == BIT_LAST) begin
            state    <= PUSH;
            tt_valid <= 1'b1;
            tt_last  <= (word_idx == WORD_LAST);
          end
        end
        PUSH: begin
          // x and tt_data hold until the word is taken
          if (tt_ready) begin
            tt_valid <= 1'b0;
            tt_last  <= 1'b0;
            if (tt_last) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= RUN;
              word_idx <= word_idx + WW'(1);
              bit_idx  <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
